// File: rtl/noc_lfsr_pkg.sv
// Shared types and helpers for the LFSR harness bit feeder.
// NOCDataH packs {data, length}, so the length sits in the low bits.
package noc_lfsr_pkg;

  localparam int NOC_DATA_WIDTH = 128;
  localparam int NOC_LEN_WIDTH  = 16;

  typedef struct packed {
    logic [NOC_DATA_WIDTH-1:0] data;
    logic [NOC_LEN_WIDTH-1:0]  length;
  } NOCDataH;

  // Oversized lengths saturate at the payload width rather than wrapping.
  function automatic logic [NOC_LEN_WIDTH-1:0] clamp_len(
    input logic [NOC_LEN_WIDTH-1:0] len
  );
    logic [NOC_LEN_WIDTH-1:0] max_len;
    max_len = NOC_LEN_WIDTH'(NOC_DATA_WIDTH);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/noc_frame_slot.sv
// One frame slot: data register, remaining-bit counter and valid flag.
// Load wins over clear and shift; MSB mode left-aligns data at load.
module noc_frame_slot #(
  parameter int DW        = 128,
  parameter int LW        = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic          i_shift,
  input  logic [DW-1:0] i_data,
  input  logic [LW-1:0] i_len,
  output logic          o_valid,
  output logic          o_bit,
  output logic          o_last,
  output logic [DW-1:0] o_data,
  output logic [LW-1:0] o_len
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [LW-1:0] r_rem;
  logic [LW-1:0] w_sh;

  assign w_sh = LW'(DW) - i_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rem   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= MSB_FIRST ? (i_data << w_sh) : i_data;
      r_rem   <= i_len;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rem   <= '0;
    end else if (i_shift) begin
      r_data  <= MSB_FIRST ? (r_data << 1) : (r_data >> 1);
      r_rem   <= r_rem - LW'(1);
      r_valid <= (r_rem != LW'(1));
    end
  end

  assign o_valid = r_valid;
  assign o_bit   = r_valid & (MSB_FIRST ? r_data[DW-1] : r_data[0]);
  assign o_last  = r_valid & (r_rem == LW'(1));
  assign o_data  = r_data;
  assign o_len   = r_rem;

endmodule

// File: rtl/noc_lfsr_bit_feeder.sv
// Serializes NOCDataH frames one bit per transfer into shiftBit.
// Active slot shifts; pending slot only holds the next frame.
module noc_lfsr_bit_feeder
  import noc_lfsr_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int LEN_WIDTH  = NOC_LEN_WIDTH,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          enq__ENA,
  input  logic [LEN_WIDTH+DATA_WIDTH-1:0] enq_v,
  output logic                          enq__RDY,
  output logic                          shiftBit__ENA,
  output logic                          shiftBit_v,
  input  logic                          shiftBit__RDY,
  output logic                          frameDone,
  output logic [7:0]                    dropCount
);

  NOCDataH               w_in;
  logic [LEN_WIDTH-1:0]  w_len;
  logic                  w_acc, w_zero, w_good;
  logic                  w_xfer, w_done, w_free;
  logic                  w_a_valid, w_a_bit, w_a_last;
  logic                  w_a_load;
  logic [DATA_WIDTH-1:0] w_a_data;
  logic [LEN_WIDTH-1:0]  w_a_len;
  logic                  w_p_valid, w_p_load, w_p_clear;
  logic [DATA_WIDTH-1:0] w_p_data;
  logic [LEN_WIDTH-1:0]  w_p_len;
  logic [7:0]            r_drop;

  assign w_in   = enq_v;
  assign w_len  = clamp_len(w_in.length);

  assign enq__RDY = !RST && !w_p_valid;
  assign w_acc    = enq__ENA && enq__RDY;
  assign w_zero   = (w_len == '0);
  assign w_good   = w_acc && !w_zero;

  assign w_xfer = w_a_valid && shiftBit__RDY;
  assign w_done = w_xfer && w_a_last;
  assign w_free = !w_a_valid || w_done;

  // Pending always promotes before a fresh frame may take the active slot.
  assign w_a_load  = w_free && (w_p_valid || w_good);
  assign w_a_data  = w_p_valid ? w_p_data : w_in.data;
  assign w_a_len   = w_p_valid ? w_p_len  : w_len;
  assign w_p_load  = w_good && !w_free;
  assign w_p_clear = w_free && w_p_valid;

  noc_frame_slot #(
    .DW(DATA_WIDTH), .LW(LEN_WIDTH), .MSB_FIRST(MSB_FIRST)
  ) u_active (
    .clk(CLK), .rst(RST),
    .i_load(w_a_load), .i_clear(1'b0), .i_shift(w_xfer),
    .i_data(w_a_data), .i_len(w_a_len),
    .o_valid(w_a_valid), .o_bit(w_a_bit), .o_last(w_a_last),
    .o_data(), .o_len()
  );

  noc_frame_slot #(
    .DW(DATA_WIDTH), .LW(LEN_WIDTH), .MSB_FIRST(1'b0)
  ) u_pending (
    .clk(CLK), .rst(RST),
    .i_load(w_p_load), .i_clear(w_p_clear), .i_shift(1'b0),
    .i_data(w_in.data), .i_len(w_len),
    .o_valid(w_p_valid), .o_bit(), .o_last(),
    .o_data(w_p_data), .o_len(w_p_len)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_drop <= '0;
    end else if (w_acc && w_zero && r_drop != 8'hFF) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign shiftBit__ENA = w_xfer;
  assign shiftBit_v    = w_a_bit;
  assign frameDone     = w_done;
  assign dropCount     = r_drop;

  a_enq_proto: assert property (
    @(posedge CLK) disable iff (RST) !(enq__ENA && !enq__RDY)
  );

endmodule

// File: tb/tb_noc_lfsr_bit_feeder.sv
// Random and directed bench for noc_lfsr_bit_feeder, LSB and MSB instances.
// Reference model tracks frames as (data, length, bit index).
module tb_noc_lfsr_bit_feeder;
  import noc_lfsr_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enq_ena = 1'b0;
  logic [143:0] enq_v = '0;
  logic         sb_rdy = 1'b0;
  logic         rdy[2], sena[2], sbit[2], done[2];
  logic [7:0]   drop[2];

  int n_vec = 0, n_err = 0;
  int c_xfer = 0, c_ones = 0, c_done = 0;

  bit           m_act_v = 0, m_pend_v = 0;
  logic [127:0] m_act_d = '0, m_pend_d = '0;
  int           m_act_n = 0, m_act_p = 0, m_pend_n = 0, m_drop = 0;

  always #5 clk = ~clk;

  noc_lfsr_bit_feeder #(.MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .RST(rst),
    .enq__ENA(enq_ena), .enq_v(enq_v), .enq__RDY(rdy[0]),
    .shiftBit__ENA(sena[0]), .shiftBit_v(sbit[0]),
    .shiftBit__RDY(sb_rdy),
    .frameDone(done[0]), .dropCount(drop[0])
  );

  noc_lfsr_bit_feeder #(.MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .RST(rst),
    .enq__ENA(enq_ena), .enq_v(enq_v), .enq__RDY(rdy[1]),
    .shiftBit__ENA(sena[1]), .shiftBit_v(sbit[1]),
    .shiftBit__RDY(sb_rdy),
    .frameDone(done[1]), .dropCount(drop[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int k);
    if (!m_act_v) return 1'b0;
    if (k == 0) return m_act_d[m_act_p];
    return m_act_d[m_act_n-1-m_act_p];
  endfunction

  task automatic model_reset();
    m_act_v = 0; m_pend_v = 0; m_act_p = 0; m_act_n = 0; m_drop = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_rdy%0d", tag, k), rdy[k], 1'b0);
      chk($sformatf("%s_ena%0d", tag, k), sena[k], 1'b0);
      chk($sformatf("%s_bit%0d", tag, k), sbit[k], 1'b0);
      chk($sformatf("%s_done%0d", tag, k), done[k], 1'b0);
      chk($sformatf("%s_drop%0d", tag, k), drop[k], 8'd0);
    end
  endtask

  task automatic step(input logic e, input logic [15:0] len,
                      input logic [127:0] d, input logic r);
    bit xfer, acc;
    int eff;
    enq_ena = e && !m_pend_v;
    enq_v   = {d, len};
    sb_rdy  = r;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rdy%0d", k), rdy[k], !m_pend_v);
      chk($sformatf("ena%0d", k), sena[k], m_act_v && r);
      chk($sformatf("bit%0d", k), sbit[k], exp_bit(k));
      chk($sformatf("done%0d", k), done[k],
          m_act_v && r && (m_act_p == m_act_n - 1));
      chk($sformatf("drop%0d", k), drop[k], m_drop);
    end
    if (sena[0]) begin
      c_xfer++;
      c_ones += int'(sbit[0]);
    end
    if (done[0]) c_done++;
    @(posedge clk);
    xfer = m_act_v && r;
    acc  = enq_ena;
    if (xfer) begin
      m_act_p++;
      if (m_act_p == m_act_n) m_act_v = 0;
    end
    if (acc) begin
      eff = (len > 16'd128) ? 128 : int'(len);
      if (eff == 0) begin
        if (m_drop < 255) m_drop++;
      end else if (!m_act_v) begin
        m_act_v = 1; m_act_d = d; m_act_n = eff; m_act_p = 0;
      end else begin
        m_pend_v = 1; m_pend_d = d; m_pend_n = eff;
      end
    end
    if (!m_act_v && m_pend_v) begin
      m_act_v = 1; m_act_d = m_pend_d; m_act_n = m_pend_n; m_act_p = 0;
      m_pend_v = 0;
    end
    #1;
    enq_ena = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, '0, 1'b1);
  endtask

  task automatic clr_counts();
    c_xfer = 0; c_ones = 0; c_done = 0;
  endtask

  initial begin
    logic [15:0]  len;
    logic [127:0] d;
    #3;
    check_reset_outs("por");
    @(posedge clk);
    #1 rst = 1'b0;

    clr_counts();
    step(1'b1, 16'd8, 128'hA5, 1'b1);
    idle(9);
    chk("a5_xfers", c_xfer, 8);
    chk("a5_done", c_done, 1);

    clr_counts();
    step(1'b1, 16'd3, 128'b110, 1'b1);
    step(1'b1, 16'd2, 128'b01, 1'b1);
    idle(6);
    chk("b2b_xfers", c_xfer, 5);
    chk("b2b_done", c_done, 2);

    clr_counts();
    step(1'b1, 16'd4, 128'h9, 1'b1);
    step(1'b0, 16'd0, '0, 1'b1);
    step(1'b0, 16'd0, '0, 1'b0);
    step(1'b0, 16'd0, '0, 1'b0);
    idle(4);
    chk("stall_xfers", c_xfer, 4);
    chk("stall_done", c_done, 1);

    clr_counts();
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'd0, {4{$urandom}}, 1'b1);
    step(1'b1, 16'd300, {128{1'b1}}, 1'b1);
    idle(130);
    chk("clamp_drop", drop[0], 8'd3);
    chk("clamp_xfers", c_xfer, 128);
    chk("clamp_ones", c_ones, 128);
    chk("clamp_done", c_done, 1);

    step(1'b1, 16'd10, {4{$urandom}}, 1'b1);
    step(1'b1, 16'd5, {4{$urandom}}, 1'b1);
    idle(4);
    chk("mid_pend", rdy[0], 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outs("async");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    clr_counts();
    idle(6);
    chk("post_rst_xfers", c_xfer, 0);

    for (int i = 0; i < 260; i++) step(1'b1, 16'd0, '0, 1'b1);
    chk("drop_sat", drop[0], 8'hFF);
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       len = 16'd0;
        1:       len = 16'($urandom_range(129, 400));
        2:       len = 16'd128;
        default: len = 16'($urandom_range(1, 12));
      endcase
      d = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 2) == 0, len, d, $urandom_range(0, 3) != 0);
    end
    idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_lfsr_bit_feeder.md
Name: noc_lfsr_bit_feeder

Overview:
- Upstream stimulus stage for the LFSR equivalence harness.
- Accepts NOCDataH frames (128-bit data, 16-bit bit-length) on a PipeIn-style enq port and serializes them one bit per transfer into the harness shiftBit method.
- Has a two-deep frame buffer (active and pending), so back-to-back frames stream without a bubble.
- Reports frame completion and dropped frames for the bench.

Parameters:
- DATA_WIDTH, 128, payload width of NOCDataH.data.
- LEN_WIDTH, 16, width of NOCDataH.length (count of valid bits).
- MSB_FIRST, 0, bit order. 0 sends data[0] first; 1 sends data[len-1] first.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- enq__ENA  in  1  frame enqueue strobe. Legal only while enq__RDY=1.
- enq$v  in  LEN_WIDTH+DATA_WIDTH  NOCDataH {data, length}; length in the low LEN_WIDTH bits.
- enq__RDY  out  1  frame buffer can accept a frame.
- shiftBit__ENA  out  1  bit transfer strobe to downstream.
- shiftBit$v  out  1  serialized bit.
- shiftBit__RDY  in  1  downstream ready.
- frameDone  out  1  one-cycle pulse on the cycle the last bit of a frame transfers.
- dropCount  out  8  saturating count of zero-length frames discarded.

Behaviour:
- Reset (async, RST=1):
  - active and pending slots invalid; remaining counter=0.
  - enq__RDY=1 once RST deasserts (0 while RST=1).
  - shiftBit__ENA=0, shiftBit$v=0, frameDone=0, dropCount=0.
- Effective length is min(length, DATA_WIDTH). Lengths above 128 are clamped, not wrapped.
- enq__RDY = !pending_valid.
- Enqueue with effective length 0:
  - frame is accepted and discarded; dropCount increments and saturates at 255.
  - no bits are sent and frameDone does not pulse.
- Enqueue with length>0:
  - if active is empty, or active is finishing its last bit this cycle, the frame loads into active; otherwise it loads into pending.
  - if both active-load and pending-to-active promotion are possible in one cycle, pending promotes first and the new frame goes to pending.
- State machine per active slot:
  - IDLE (active invalid): shiftBit__ENA=0.
  - SHIFT (active valid): remaining = bits left. shiftBit__ENA = shiftBit__RDY (combinational). shiftBit$v = active[0] (LSB mode) or active[DATA_WIDTH-1] (MSB mode, after left-aligning data by DATA_WIDTH-len at load).
  - A transfer occurs when shiftBit__ENA=1. On transfer: shift one position, remaining decrements.
  - SHIFT -> SHIFT when remaining>1.
  - On transfer with remaining==1: frameDone=1 that cycle. Active is reloaded the same cycle from pending (or from a concurrent enq if pending is empty); otherwise active goes to IDLE.
- Latency:
  - first bit is presented on the cycle after the enq into an empty block.
  - back-to-back frames have zero idle cycles between the last bit of frame N and the first bit of frame N+1.
- Stall: while shiftBit__RDY=0, shiftBit$v holds, remaining holds and no state changes.
- Reset mid-frame discards both slots immediately. No frameDone is produced for the aborted frame.
- enq__ENA while enq__RDY=0 is a protocol violation. It is ignored; a simulation assertion fires.

Decomposition:
- Shared package noc_lfsr_pkg:
  - NOCDataH struct typedef.
  - constants NOC_DATA_WIDTH=128 and NOC_LEN_WIDTH=16.
  - clamp_len function.
- One natural sub-module: noc_frame_slot (data register, remaining counter, shift logic, valid flag). It is instantiated twice (active and pending), with pending used as a load-only slot.

Test Plan:
- Single frame, data=0xA5, length=8, LSB mode, RDY=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting cycle+1; frameDone on the 8th; enq__RDY stays 1.
- Same frame with MSB_FIRST=1 -> bits 1,0,1,0,0,1,0,1 in reversed-index order (data[7] first); frameDone on the 8th transfer.
- Two frames back-to-back (len=3 data=0b110, then len=2 data=0b01), RDY=1 -> stream 0,1,1,1,0 with no gap; frameDone pulses at transfers 3 and 5; enq__RDY drops to 0 only while pending is occupied.
- shiftBit__RDY toggled 1,0,0,1 during a len=4 frame -> shiftBit$v holds across the stalls; exactly 4 transfers; frameDone only on the 4th.
- length=0 enqueued three times, then length=300 with data=all-ones -> dropCount=3; exactly 128 ones transferred; one frameDone.
- RST asserted asynchronously mid-frame (bit 5 of 10) with pending full -> outputs reach reset values without a clock edge; after release enq__RDY=1 and no stale bits are emitted.
